// File: rtl/fp_mul_operand_loader.sv
// Byte-serial loader for the FP multiplier: assembles two binary64 operands,
// unpacks sign/exp/mantissa/class and offers them to the core on valid/ready.
//
// Ports:
//   CLK, RESET (sync, active-high), ENABLE + DATA_IN[7:0] frame input,
//   OP_VALID/OP_READY handshake, A_/B_ SIGN, EXP[EXP_W-1:0] (signed),
//   MAN[52:0], CLASS[2:0], BUSY, ERR_FRAME (one-cycle pulse).
//
// Option: FP_LOADER_NORMALIZE_EN adds a NORM state that shifts subnormal
// mantissas left one bit per cycle until the hidden bit is set.
module fp_mul_operand_loader #(
  parameter int BYTES_PER_OP = 8,
  parameter int EXP_W        = 12
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [7:0]       DATA_IN,
  output logic             OP_VALID,
  input  logic             OP_READY,
  output logic             A_SIGN,
  output logic [EXP_W-1:0] A_EXP,
  output logic [52:0]      A_MAN,
  output logic [2:0]       A_CLASS,
  output logic             B_SIGN,
  output logic [EXP_W-1:0] B_EXP,
  output logic [52:0]      B_MAN,
  output logic [2:0]       B_CLASS,
  output logic             BUSY,
  output logic             ERR_FRAME
);

  typedef enum logic [1:0] {
    IDLE, LOAD, NORM, HOLD
  } state_t;

  localparam logic [3:0] LAST = 4'(2 * BYTES_PER_OP - 1);
  localparam logic [2:0] C_ZERO = 3'd0;
  localparam logic [2:0] C_SUB  = 3'd1;
  localparam logic [2:0] C_NORM = 3'd2;
  localparam logic [2:0] C_INF  = 3'd3;
  localparam logic [2:0] C_QNAN = 3'd4;
  localparam logic [2:0] C_SNAN = 3'd5;

  state_t state, state_n;
  logic [3:0]   cnt;
  logic [119:0] frame;
  logic         hold_off, hold_off_n;
  logic         err_n, store, cap;

  logic [63:0]      word_a, word_b;
  logic [2:0]       ua_cls, ub_cls;
  logic [EXP_W-1:0] ua_exp, ub_exp;
  logic [52:0]      ua_man, ub_man;

  function automatic logic [EXP_W+55:0] unpack(input logic [63:0] w);
    logic [10:0]      e;
    logic [51:0]      f;
    logic [2:0]       c;
    logic [EXP_W-1:0] x;
    logic [52:0]      m;
    e = w[62:52];
    f = w[51:0];
    if (e == 11'd0) begin
      if (f == 52'd0) begin
        c = C_ZERO; x = '0; m = '0;
      end else begin
        c = C_SUB; x = EXP_W'(-1022); m = {1'b0, f};
      end
    end else if (e == 11'h7ff) begin
      x = EXP_W'(1024);
      if (f == 52'd0) begin
        c = C_INF; m = '0;
      end else begin
        c = f[51] ? C_QNAN : C_SNAN;
        m = {1'b0, f};
      end
    end else begin
      c = C_NORM;
      x = EXP_W'(e) - EXP_W'(1023);
      m = {1'b1, f};
    end
    return {c, x, m};
  endfunction

  // B's top byte is still on DATA_IN when the frame completes.
  assign word_a = frame[63:0];
  assign word_b = {DATA_IN, frame[119:64]};
  assign {ua_cls, ua_exp, ua_man} = unpack(word_a);
  assign {ub_cls, ub_exp, ub_man} = unpack(word_b);

`ifdef FP_LOADER_NORMALIZE_EN
  logic a_shift, b_shift, norm_done;
  assign a_shift = (A_CLASS == C_SUB) && !A_MAN[52];
  assign b_shift = (B_CLASS == C_SUB) && !B_MAN[52];
  // Done once this cycle's shift lands the leading one in bit 52.
  assign norm_done = (!a_shift || A_MAN[51]) &&
                     (!b_shift || B_MAN[51]);
`endif

  always_comb begin
    state_n    = state;
    hold_off_n = hold_off;
    err_n      = 1'b0;
    store      = 1'b0;
    cap        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!ENABLE) begin
          hold_off_n = 1'b0;
        end else if (!hold_off) begin
          store   = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (ENABLE) begin
          store = 1'b1;
          if (cnt == LAST) begin
            cap     = 1'b1;
            state_n = HOLD;
`ifdef FP_LOADER_NORMALIZE_EN
            if (ua_cls == C_SUB || ub_cls == C_SUB)
              state_n = NORM;
`endif
          end
        end else begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      NORM, HOLD: begin
        // Stray bytes: flag once, then lock out until ENABLE drops.
        if (ENABLE && !hold_off) begin
          err_n      = 1'b1;
          hold_off_n = 1'b1;
        end else if (!ENABLE) begin
          hold_off_n = 1'b0;
        end
        if (state == HOLD) begin
          if (OP_READY) state_n = IDLE;
        end else begin
`ifdef FP_LOADER_NORMALIZE_EN
          if (norm_done) state_n = HOLD;
`else
          state_n = HOLD;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      frame     <= '0;
      hold_off  <= ENABLE;
      OP_VALID  <= 1'b0;
      BUSY      <= 1'b0;
      ERR_FRAME <= 1'b0;
      A_SIGN    <= 1'b0;
      A_EXP     <= '0;
      A_MAN     <= '0;
      A_CLASS   <= '0;
      B_SIGN    <= 1'b0;
      B_EXP     <= '0;
      B_MAN     <= '0;
      B_CLASS   <= '0;
    end else begin
      state     <= state_n;
      hold_off  <= hold_off_n;
      OP_VALID  <= (state_n == HOLD);
      BUSY      <= (state_n != IDLE);
      ERR_FRAME <= err_n;
      cnt       <= store ? cnt + 4'd1 : 4'd0;
      if (store && cnt != LAST)
        frame[{cnt, 3'b000} +: 8] <= DATA_IN;
      if (cap) begin
        A_SIGN  <= word_a[63];
        A_EXP   <= ua_exp;
        A_MAN   <= ua_man;
        A_CLASS <= ua_cls;
        B_SIGN  <= word_b[63];
        B_EXP   <= ub_exp;
        B_MAN   <= ub_man;
        B_CLASS <= ub_cls;
      end
`ifdef FP_LOADER_NORMALIZE_EN
      else if (state == NORM) begin
        if (a_shift) begin
          A_MAN <= A_MAN << 1;
          A_EXP <= A_EXP - EXP_W'(1);
        end
        if (b_shift) begin
          B_MAN <= B_MAN << 1;
          B_EXP <= B_EXP - EXP_W'(1);
        end
      end
`endif
    end
  end

endmodule
